// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the register file and its scoreboard: widths, the
// writeback-to-decode bundle layout, and a register-number helper.
package regfile_sb_pkg;

    localparam int DBITS     = 32;
    localparam int REGNOBITS = 5;
    localparam int REGWORDS  = 32;
    localparam int CNTBITS   = 2;

    // Writeback-to-decode bundle, fields in {wr_reg, wregno, regval} order
    typedef struct packed {
        logic                 wr_reg;
        logic [REGNOBITS-1:0] wregno;
        logic [DBITS-1:0]     regval;
    } from_wb_to_de_t;

    localparam int FROM_WB_TO_DE_BITS = $bits(from_wb_to_de_t);

    // True for a register that exists and is not the hardwired zero register
    function automatic logic reg_in_use(input logic [REGNOBITS-1:0] r, input int words);
        return (r != '0) && (int'(r) < words);
    endfunction

endpackage

// File: rtl/regfile_sb_array.sv
// Register data array: one synchronous write port and two combinational read
// ports, with register 0 hardwired to zero.
module regfile_array
#(
    parameter int DBITS    = regfile_sb_pkg::DBITS,
    parameter int REGWORDS = regfile_sb_pkg::REGWORDS
)(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 we,
    input  logic [regfile_sb_pkg::REGNOBITS-1:0] waddr,
    input  logic [DBITS-1:0]                     wdata,
    input  logic [regfile_sb_pkg::REGNOBITS-1:0] raddr1,
    input  logic [regfile_sb_pkg::REGNOBITS-1:0] raddr2,
    output logic [DBITS-1:0]                     rdata1,
    output logic [DBITS-1:0]                     rdata2
);
    import regfile_sb_pkg::reg_in_use;

    logic [DBITS-1:0] regs [REGWORDS];

    // Reset takes priority so a writeback landing in the reset cycle is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REGWORDS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && reg_in_use(waddr, REGWORDS)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = reg_in_use(raddr1, REGWORDS) ? regs[raddr1] : '0;
    assign rdata2 = reg_in_use(raddr2, REGWORDS) ? regs[raddr2] : '0;

endmodule

// File: rtl/regfile_sb.sv
// Register file with a per-register in-flight writer scoreboard and decode stall.
// Define REGFILE_WB_BYPASS_EN to forward the writeback value to same-cycle readers.
module regfile_sb
#(
    parameter int DBITS    = regfile_sb_pkg::DBITS,
    parameter int REGWORDS = regfile_sb_pkg::REGWORDS,
    parameter int CNTBITS  = regfile_sb_pkg::CNTBITS
)(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wb_wr_reg,
    input  logic [regfile_sb_pkg::REGNOBITS-1:0] wb_wregno,
    input  logic [DBITS-1:0]                     wb_regval,
    input  logic [regfile_sb_pkg::REGNOBITS-1:0] rs1_no,
    input  logic [regfile_sb_pkg::REGNOBITS-1:0] rs2_no,
    output logic [DBITS-1:0]                     rs1_val,
    output logic [DBITS-1:0]                     rs2_val,
    input  logic                                 issue_valid,
    input  logic                                 issue_wr_reg,
    input  logic [regfile_sb_pkg::REGNOBITS-1:0] issue_rd,
    output logic                                 stall,
    output logic                                 sb_err
);
    import regfile_sb_pkg::*;

    logic [CNTBITS-1:0] cnt [REGWORDS];
    logic [CNTBITS-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
    logic [DBITS-1:0]   arr_rs1, arr_rs2;
    logic               wb_active, hit1, hit2, pend1, pend2, saturated;
    logic               inc, dec, underflow;

    regfile_array #(
        .DBITS    (DBITS),
        .REGWORDS (REGWORDS)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_wr_reg),
        .waddr  (wb_wregno),
        .wdata  (wb_regval),
        .raddr1 (rs1_no),
        .raddr2 (rs2_no),
        .rdata1 (arr_rs1),
        .rdata2 (arr_rs2)
    );

    // A source that is being retired this cycle by its last writer can be
    // forwarded instead of stalling, but only when bypass is built in.
    always_comb begin
        cnt_rs1   = reg_in_use(rs1_no,    REGWORDS) ? cnt[rs1_no]    : '0;
        cnt_rs2   = reg_in_use(rs2_no,    REGWORDS) ? cnt[rs2_no]    : '0;
        cnt_rd    = reg_in_use(issue_rd,  REGWORDS) ? cnt[issue_rd]  : '0;
        cnt_wb    = reg_in_use(wb_wregno, REGWORDS) ? cnt[wb_wregno] : '0;
        wb_active = wb_wr_reg && reg_in_use(wb_wregno, REGWORDS);
`ifdef REGFILE_WB_BYPASS_EN
        hit1      = wb_active && (wb_wregno == rs1_no);
        hit2      = wb_active && (wb_wregno == rs2_no);
`else
        hit1      = 1'b0;
        hit2      = 1'b0;
`endif
        pend1     = (cnt_rs1 != '0) && !(hit1 && cnt_rs1 == CNTBITS'(1));
        pend2     = (cnt_rs2 != '0) && !(hit2 && cnt_rs2 == CNTBITS'(1));
        rs1_val   = hit1 ? wb_regval : arr_rs1;
        rs2_val   = hit2 ? wb_regval : arr_rs2;
        saturated = issue_wr_reg && reg_in_use(issue_rd, REGWORDS) && (cnt_rd == '1);
        stall     = issue_valid && (pend1 || pend2 || saturated);
        inc       = issue_valid && !stall && issue_wr_reg && reg_in_use(issue_rd, REGWORDS);
        dec       = wb_active && (cnt_wb != '0);
        underflow = wb_active && (cnt_wb == '0);
    end

    // Counters track issued-but-not-retired writers; a same-cycle issue and
    // retire on one register cancel out. Underflow latches sb_err until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REGWORDS; i++) begin
                cnt[i] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            for (int i = 0; i < REGWORDS; i++) begin
                if (inc && (issue_rd == REGNOBITS'(i)) && !(dec && (wb_wregno == REGNOBITS'(i)))) begin
                    cnt[i] <= cnt[i] + CNTBITS'(1);
                end else if (dec && (wb_wregno == REGNOBITS'(i)) && !(inc && (issue_rd == REGNOBITS'(i)))) begin
                    cnt[i] <= cnt[i] - CNTBITS'(1);
                end
            end
            if (underflow) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; honours REGFILE_WB_BYPASS_EN
// when the design is built with it.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_wr_reg;
    logic [4:0]  wb_wregno;
    logic [31:0] wb_regval;
    logic [4:0]  rs1_no, rs2_no;
    logic [31:0] rs1_val, rs2_val;
    logic        issue_valid, issue_wr_reg;
    logic [4:0]  issue_rd;
    logic        stall, sb_err;

    int total = 0;
    int bad   = 0;

    regfile_sb dut (
        .clk          (clk),
        .reset        (reset),
        .wb_wr_reg    (wb_wr_reg),
        .wb_wregno    (wb_wregno),
        .wb_regval    (wb_regval),
        .rs1_no       (rs1_no),
        .rs2_no       (rs2_no),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .issue_valid  (issue_valid),
        .issue_wr_reg (issue_wr_reg),
        .issue_rd     (issue_rd),
        .stall        (stall),
        .sb_err       (sb_err)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; combinational outputs settle 1ns later
    task automatic applyStimulus(input logic rst, input logic iv, input logic iwr,
                                 input logic [4:0] ird, input logic [4:0] r1,
                                 input logic [4:0] r2, input logic wwr,
                                 input logic [4:0] wno, input logic [31:0] wval);
        @(negedge clk);
        reset        = rst;
        issue_valid  = iv;
        issue_wr_reg = iwr;
        issue_rd     = ird;
        rs1_no       = r1;
        rs2_no       = r2;
        wb_wr_reg    = wwr;
        wb_wregno    = wno;
        wb_regval    = wval;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        applyStimulus(0, 1, 0, 0, 5, 0, 0, 0, 0);
        checkOutput("reset_stall", stall, 0);
        checkOutput("reset_x5", rs1_val, 0);
        checkOutput("reset_err", sb_err, 0);

        // Basic write/read, x0 stays zero
        applyStimulus(0, 1, 1, 5, 0, 0, 0, 0, 0);
        checkOutput("issue_x5_stall", stall, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
        applyStimulus(0, 1, 0, 0, 5, 0, 1, 0, 32'h1234);
        checkOutput("x5_read", rs1_val, 32'hDEADBEEF);
        checkOutput("x5_nostall", stall, 0);
        applyStimulus(0, 0, 0, 0, 5, 0, 0, 0, 0);
        checkOutput("x0_read", rs2_val, 0);
        checkOutput("x0_noerr", sb_err, 0);

        // RAW hazard on x7
        applyStimulus(0, 1, 1, 7, 0, 0, 0, 0, 0);
        checkOutput("issue_x7", stall, 0);
        applyStimulus(0, 1, 0, 0, 0, 7, 0, 0, 0);
        checkOutput("raw_stall_a", stall, 1);
        applyStimulus(0, 1, 0, 0, 0, 7, 0, 0, 0);
        checkOutput("raw_stall_b", stall, 1);
        applyStimulus(0, 1, 0, 0, 0, 7, 1, 7, 32'h55);
`ifdef REGFILE_WB_BYPASS_EN
        checkOutput("wb_cycle_stall", stall, 0);
        checkOutput("wb_cycle_rs2", rs2_val, 32'h55);
`else
        checkOutput("wb_cycle_stall", stall, 1);
        checkOutput("wb_cycle_rs2", rs2_val, 0);
`endif
        applyStimulus(0, 1, 0, 0, 0, 7, 0, 0, 0);
        checkOutput("after_wb_stall", stall, 0);
        checkOutput("after_wb_rs2", rs2_val, 32'h55);
        checkOutput("cnt7_clear", dut.cnt[7], 0);

        // Saturation on x3
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 3, 0, 0, 0, 0, 0);
            checkOutput($sformatf("issue_x3_%0d", i), stall, 0);
        end
        applyStimulus(0, 1, 1, 3, 0, 0, 0, 0, 0);
        checkOutput("cnt3_three", dut.cnt[3], 3);
        checkOutput("sat_stall", stall, 1);
        idle();
        checkOutput("cnt3_held", dut.cnt[3], 3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 32'h30 + i);
        end
        idle();
        checkOutput("cnt3_drained", dut.cnt[3], 0);
        checkOutput("drain_noerr", sb_err, 0);

        // Same-cycle issue and retire on x9
        applyStimulus(0, 1, 1, 9, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 9, 0, 0, 1, 9, 32'hA5A5);
        checkOutput("x9_both_stall", stall, 0);
        applyStimulus(0, 0, 0, 0, 9, 0, 0, 0, 0);
        checkOutput("cnt9_kept", dut.cnt[9], 1);
        checkOutput("x9_data", rs1_val, 32'hA5A5);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 32'hA5A5);
        idle();
        checkOutput("cnt9_clear", dut.cnt[9], 0);
        checkOutput("pre_underflow_err", sb_err, 0);

        // Underflow on x4 sets a sticky error
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4, 32'h44);
        applyStimulus(0, 0, 0, 0, 4, 0, 0, 0, 0);
        checkOutput("x4_data", rs1_val, 32'h44);
        checkOutput("underflow_err", sb_err, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 6, 32'h66);
        idle();
        idle();
        checkOutput("err_sticky", sb_err, 1);

        // Reset mid-operation with x6 in flight
        applyStimulus(0, 1, 1, 6, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 6, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 6, 0, 0, 0, 0);
        checkOutput("cnt6_two", dut.cnt[6], 2);
        checkOutput("x6_before_reset", rs1_val, 32'h66);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 5, 32'h99);
        applyStimulus(0, 1, 0, 0, 6, 5, 0, 0, 0);
        checkOutput("cnt6_reset", dut.cnt[6], 0);
        checkOutput("x6_reset_stall", stall, 0);
        checkOutput("x6_reset_val", rs1_val, 0);
        checkOutput("x5_reset_wb_dropped", rs2_val, 0);
        checkOutput("err_reset", sb_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
